// File: rtl/ram_master_pkg.sv
// Shared definitions for the RAM burst master: default widths, FSM
// state encoding and the read-issue admission rule.
package ram_master_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // A read may be issued only if the 2-entry FIFO can absorb every
  // word already buffered, every word still in the RAM pipeline, and this one.
  function automatic logic can_issue(input logic [1:0] fifo_count, input logic inflight);
    return ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
  endfunction

endpackage

// File: rtl/ram_burst_master_rd_fifo2.sv
// Two-entry output FIFO for read data. Simultaneous push and pop keeps the
// occupancy unchanged and preserves ordering; pushes into a full FIFO
// without a pop are dropped (the master never issues such a push).
module rd_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic              pop_ok;
  logic              push_ok;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= {DATA_W{1'b0}};
      mem_q[1] <= {DATA_W{1'b0}};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst master for a single-port synchronous RAM. Accepts write/read
// burst commands, streams write data straight into the RAM and returns
// read data through a 2-entry FIFO with back-pressure.
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] beats_q;
  logic              inflight_q;
  logic              wr_hs;
  logic              rd_issue;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Beat qualification and RAM port drive; everything decodes from
  // registers, so an asynchronous reset clears the RAM port at once.
  always_comb begin
    wr_hs    = (state_q == WRITE) && wr_valid;
    rd_issue = (state_q == READ) && can_issue(fifo_count, inflight_q);
    ram_we   = wr_hs;
    ram_addr = addr_q;
    if (wr_hs) begin
      ram_data = wr_data;
    end else begin
      ram_data = {DATA_W{1'b0}};
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign rd_valid  = (fifo_count != 2'd0);
  assign rd_data   = fifo_head;
  assign fifo_pop  = rd_valid && rd_ready;

  // Burst sequencing: address/beat tracking and the read pipeline flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      beats_q    <= {ADDR_W{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            beats_q <= cmd_len;
            state_q <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (beats_q == {ADDR_W{1'b0}}) begin
              state_q <= IDLE;
            end else begin
              beats_q <= beats_q - ADDR_W'(1);
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (beats_q == {ADDR_W{1'b0}}) begin
              state_q <= DRAIN;
            end else begin
              beats_q <= beats_q - ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!inflight_q && (fifo_count == 2'd0)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM read data lands one cycle after the issue and is pushed then.
  rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (ram_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized self-checking bench for ram_burst_master with a behavioural
// RAM, an expected-write queue and an expected-read-data queue.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0] cmd_addr = 6'd0, cmd_len = 6'd0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = 8'd0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_data, ram_q;
  logic       busy;

  typedef struct { logic [5:0] a; logic [7:0] d; } wr_t;

  logic [7:0] tb_ram  [64];
  logic [7:0] ref_mem [64];
  wr_t        exp_wq[$];
  logic [7:0] exp_rq[$];
  logic       pl_en = 1'b0;
  logic [5:0] pl_a = 6'd0;
  logic [7:0] pl_d = 8'd0;
  int         n_vec = 0, n_err = 0;
  int         cyc = 0, acc_cyc = 0, we_cnt = 0;
  bit         first_seen = 1'b0;

  ram_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM: registered read, write on we.
  always @(posedge clk) begin
    if (pl_en) tb_ram[pl_a] <= pl_d;
    else if (ram_we) tb_ram[ram_addr] <= ram_data;
    ram_q <= tb_ram[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycle monitor: RAM writes, read stream ordering, FIFO occupancy bound.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_wq.size() == 0) check_eq("idle_we", ram_we, 1'b0);
      else if (!wr_valid) check_eq("gap_we", ram_we, 1'b0);
      else if (ram_we) begin
        check_eq("wr_addr", ram_addr, exp_wq[0].a);
        check_eq("wr_data", ram_data, exp_wq[0].d);
        void'(exp_wq.pop_front());
      end
      if (ram_we) we_cnt++;
      if (exp_rq.size() == 0) check_eq("idle_rdv", rd_valid, 1'b0);
      else if (rd_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          check_eq("rd_latency_ge2", ((cyc - acc_cyc) >= 2), 1'b1);
        end
        if (rd_ready) begin
          check_eq("rd_data", rd_data, exp_rq[0]);
          void'(exp_rq.pop_front());
        end
      end
      check_eq("fifo_occ_le2", (dut.u_fifo.count_o <= 2'd2), 1'b1);
    end
  end

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d; ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [5:0] l);
    int k;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (cmd_ready) break;
      @(posedge clk); #1;
      k++;
    end
    check_eq("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] addr, input logic [5:0] len, input int mode,
                             input int nstop, input logic [7:0] d0, input logic [7:0] inc);
    int nb, i, k, we0;
    logic [7:0] dq[$];
    nb = (nstop > 0) ? nstop : int'(len) + 1;
    for (int j = 0; j < nb; j++) begin
      wr_t w;
      w.a = addr + 6'(j);
      w.d = (inc != 8'd0) ? 8'(d0 + 8'(j) * inc) : 8'($urandom);
      dq.push_back(w.d);
      exp_wq.push_back(w);
      ref_mem[w.a] = w.d;
    end
    we0 = we_cnt;
    send_cmd(1'b1, addr, len);
    i = 0; k = 0;
    while (i < nb && k < 400) begin
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (k % 2 == 0);
        default: wr_valid = 1'($urandom);
      endcase
      wr_data = dq[i];
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    wr_valid = 1'b0;
    if (nstop == 0) begin
      @(negedge clk);
      check_eq("busy_after_wr", busy, 1'b0);
      check_eq("ready_after_wr", cmd_ready, 1'b1);
      check_eq("we_cycles", we_cnt - we0, nb);
      check_eq("wq_left", exp_wq.size(), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic read_burst(input logic [5:0] addr, input logic [5:0] len, input int mode);
    int k;
    for (int j = 0; j <= int'(len); j++) exp_rq.push_back(ref_mem[6'(addr + 6'(j))]);
    first_seen = 1'b0;
    rd_ready = (mode != 2) ? 1'b1 : 1'($urandom);
    send_cmd(1'b0, addr, len);
    k = 0;
    while ((exp_rq.size() != 0 || busy) && k < 800) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: rd_ready = 1'($urandom);
      endcase
      @(negedge clk);
      @(posedge clk); #1;
      k++;
    end
    rd_ready = 1'b0;
    check_eq("rq_left", exp_rq.size(), 0);
    check_eq("busy_after_rd", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ra, rl;
    int rm;
    // Reset values while reset is held.
    #12;
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_wr_ready", wr_ready, 1'b0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_ram_addr", ram_addr, 6'd0);
    check_eq("rst_ram_data", ram_data, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int j = 0; j < 64; j++) preload(6'(j), 8'($urandom));

    // Directed bursts.
    write_burst(6'd5, 6'd3, 0, 0, 8'h11, 8'h11);
    read_burst(6'd5, 6'd3, 0);
    preload(6'd62, 8'hA0); preload(6'd63, 8'hA1);
    preload(6'd0, 8'hA2);  preload(6'd1, 8'hA3);
    read_burst(6'd62, 6'd3, 0);
    read_burst(6'd30, 6'd7, 1);
    write_burst(6'd40, 6'd2, 1, 0, 8'h00, 8'h00);

    // Reset during a 4-beat write after 2 beats.
    write_burst(6'd20, 6'd3, 0, 2, 8'h00, 8'h00);
    wr_valid = 1'b1; wr_data = 8'h5A;
    #2 reset = 1'b1;
    #1;
    check_eq("abort_cmd_ready", cmd_ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_wr_ready", wr_ready, 1'b0);
    check_eq("abort_rd_valid", rd_valid, 1'b0);
    check_eq("abort_ram_we", ram_we, 1'b0);
    check_eq("abort_ram_addr", ram_addr, 6'd0);
    check_eq("abort_ram_data", ram_data, 8'd0);
    exp_wq.delete();
    exp_rq.delete();
    wr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    write_burst(6'd50, 6'd1, 0, 0, 8'h00, 8'h00);

    // Full 64-word burst and randomized traffic.
    write_burst(6'd10, 6'd63, 2, 0, 8'h00, 8'h00);
    read_burst(6'd33, 6'd63, 2);
    for (int it = 0; it < 12; it++) begin
      ra = 6'($urandom);
      rl = 6'($urandom_range(0, 12));
      rm = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) write_burst(ra, rl, rm, 0, 8'h00, 8'h00);
      else read_burst(ra, rl, rm);
    end

    // Final RAM image against the model.
    for (int j = 0; j < 64; j++) check_eq("ram_image", tb_ram[j], ref_mem[j]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the RAM word-address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port cmd_valid / cmd_ready, input / output, 1 each: command handshake; a command is accepted on a cycle where both are high.
REQ-006 Port cmd_write, input, 1: 1 = burst write, 0 = burst read.
REQ-007 Port cmd_addr, input, ADDR_W: burst start address.
REQ-008 Port cmd_len, input, ADDR_W: burst beats minus one (0 = 1 beat, 63 = 64 beats).
REQ-009 Port wr_valid / wr_ready / wr_data, input / output / input, 1/1/DATA_W: write-data stream.
REQ-010 Port rd_valid / rd_ready / rd_data, output / input / output, 1/1/DATA_W: read-data stream.
REQ-011 Port ram_addr / ram_we / ram_data, output, ADDR_W/1/DATA_W: drive single_port_ram addr/we/data.
REQ-012 Port ram_q, input, DATA_W: single_port_ram q; valid the cycle after the address is sampled.
REQ-013 Port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, READ and DRAIN.
REQ-015 cmd_ready SHALL be high only in IDLE; acceptance latches cmd_addr into addr_q and cmd_len into beats_q, then moves the FSM to WRITE or READ.
REQ-016 In WRITE: wr_ready = 1; each wr_valid&wr_ready cycle drives ram_we=1, ram_addr=addr_q, ram_data=wr_data the same cycle; the beat ending with beats_q==0 returns the FSM to IDLE.
REQ-017 ram_we SHALL be 0 in every cycle that is not a write handshake.
REQ-018 In READ: a read is issued (ram_addr=addr_q) only when fifo_count + inflight < 2; the last issue moves the FSM to DRAIN.
REQ-019 Each issued read SHALL push ram_q into a 2-entry output FIFO exactly one cycle later.
REQ-020 rd_valid SHALL equal "FIFO not empty", and rd_data SHALL be the FIFO head; pop occurs on rd_valid&rd_ready.
REQ-021 A simultaneous push and pop SHALL keep the FIFO count unchanged and preserve order.
REQ-022 The FIFO SHALL never overflow; with rd_ready held 0, at most 2 reads are outstanding and issuing stalls.
REQ-023 DRAIN SHALL return to IDLE when inflight==0 and the FIFO is empty.
REQ-024 addr_q SHALL increment modulo 2^ADDR_W per beat (63 -> 0 wrap).
REQ-025 A command accepted with a burst longer than 2^ADDR_W is impossible by width; cmd_len=63 SHALL touch all 64 words once.
REQ-026 Back-to-back commands SHALL be accepted no earlier than the first IDLE cycle after completion.

Reset
REQ-027 reset SHALL force within the same cycle: state=IDLE, cmd_ready=1, busy=0, wr_ready=0, rd_valid=0, ram_we=0, ram_addr=0, ram_data=0, fifo empty, inflight=0.
REQ-028 A reset asserted mid-burst SHALL abort the burst; no further RAM write occurs, and pending read data is discarded.

Structure
REQ-029 A shared package ram_master_pkg SHALL hold the ADDR_W/DATA_W defaults and the state encoding (2-bit: IDLE=0, WRITE=1, READ=2, DRAIN=3).
REQ-030 The output FIFO SHALL be a sub-module rd_fifo2 (2 entries, DATA_W wide, async active-high reset).

Verification
REQ-031 Write cmd addr=5, len=3, data 0x11,0x22,0x33,0x44 -> RAM[5..8]=0x11..0x44, ram_we high for exactly 4 cycles, busy drops after beat 4.
REQ-032 Read cmd addr=5, len=3, rd_ready=1 -> rd_data 0x11,0x22,0x33,0x44 in order, first rd_valid no earlier than 2 cycles after acceptance.
REQ-033 Read addr=62, len=3, preloaded 0xA0..0xA3 at 62,63,0,1 -> the output order is 0xA0,0xA1,0xA2,0xA3 (wrap).
REQ-034 Read len=7 with rd_ready toggling 1-0-0-1 -> all 8 words are delivered once, with no loss or duplicate, and at most 2 words are ever buffered.
REQ-035 Reset asserted during a write burst at beat 2 of 4 -> only 2 words are written, all outputs hold their reset values immediately, and a new command is accepted after reset deasserts.
REQ-036 A write with wr_valid gaps (1,0,1,0,1) at len=2 -> exactly 3 writes occur to consecutive addresses, and ram_we=0 in the gap cycles.
